// File: rtl/niosdram_pio_in.sv
// Avalon-MM input PIO: synchronised inputs, sticky edge capture, masked level irq.
// Optional per-bit debounce filter enabled by defining PIO_IN_DEBOUNCE_EN.
module niosdram_pio_in #(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      EDGE_TYPE       = 0,
   parameter logic [WIDTH-1:0] RESET_MASK      = '0,
   parameter int unsigned      DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   typedef enum logic [1:0] {WARM0, WARM1, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] s1, s2, prev;
   logic [WIDTH-1:0] cond, cond_nxt;
   logic [WIDTH-1:0] edge_term, edge_det;
   logic [WIDTH-1:0] irqmask, edgecap, clr_bits;
   logic             wr_en;

   assign wr_en    = chipselect && !write_n;
   assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] filtered, filtered_nxt;
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];

   always_comb begin
      filtered_nxt = filtered;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (state != RUN) begin
            filtered_nxt[i] = s2[i];
         end else if (s2[i] != filtered[i]) begin
            if (cnt[i] == CNT_LAST) filtered_nxt[i] = s2[i];
            else                    cnt_nxt[i] = cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         filtered <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         filtered <= filtered_nxt;
         for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      end
   end

   assign cond     = filtered;
   assign cond_nxt = filtered_nxt;
`else
   assign cond     = s2;
   assign cond_nxt = s1;
`endif

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_term = cond & ~prev;
         1:       edge_term = ~cond & prev;
         default: edge_term = cond ^ prev;
      endcase
   end

   always_comb begin
      state_nxt = state;
      edge_det  = '0;
      case (state)
         WARM0:   state_nxt = WARM1;
         WARM1:   state_nxt = RUN;
         RUN:     edge_det  = edge_term;
         default: state_nxt = WARM0;
      endcase
   end

   // During warm-up prev preloads the value cond is about to take, so the
   // first RUN comparison sees no difference for a steady input.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= WARM0;
         s1      <= '0;
         s2      <= '0;
         prev    <= '0;
         edgecap <= '0;
         irqmask <= RESET_MASK;
      end else begin
         state   <= state_nxt;
         s1      <= in_port;
         s2      <= s1;
         prev    <= (state == RUN) ? cond : cond_nxt;
         edgecap <= (edgecap & ~clr_bits) | edge_det;
         if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = cond;
         2'd2:    readdata[WIDTH-1:0] = irqmask;
         2'd3:    readdata[WIDTH-1:0] = edgecap;
         default: ;
      endcase
   end

   assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_niosdram_pio_in.sv
// Bench for niosdram_pio_in: four instances (EDGE_TYPE 0..3) on shared inputs,
// directed vector table, hand sequences and random stimulus against a history-based model.
module tb_niosdram_pio_in;

   localparam int         DC = 16;
   localparam logic [3:0] RM [4] = '{4'h0, 4'h5, 4'hF, 4'h3};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = '0;
   logic [31:0] rd  [4];
   logic        irq [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      niosdram_pio_in #(
         .WIDTH(4), .EDGE_TYPE(g), .RESET_MASK(RM[g]), .DEBOUNCE_CYCLES(DC)
      ) dut (
         .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
         .write_n(write_n), .writedata(writedata), .in_port(in_port),
         .readdata(rd[g]), .irq(irq[g])
      );
   end

   // Reference model: hist holds every in_port sampled since reset; condq holds
   // the conditioned value visible after each edge.
   logic [3:0] hist  [$];
   logic [3:0] condq [$];
   logic [3:0] m_filt;
   logic [3:0] m_cap  [4];
   logic [3:0] m_mask [4];

   task automatic model_edge();
      logic [3:0] c0, c1, ev, clr, cnew;
      logic       wr;
      int         n;
      if (!reset_n) begin
         hist.delete();
         condq.delete();
         m_filt = '0;
         for (int g = 0; g < 4; g++) begin
            m_cap[g]  = '0;
            m_mask[g] = RM[g];
         end
         return;
      end
      hist.push_back(in_port);
      n   = hist.size();
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
      // the first two conditioned samples after reset never count as edges
      if (n >= 4) begin
         c1 = condq[n-2];
         c0 = condq[n-3];
      end else begin
         c1 = '0;
         c0 = '0;
      end
      for (int g = 0; g < 4; g++) begin
         case (g)
            0:       ev = c1 & ~c0;
            1:       ev = ~c1 & c0;
            default: ev = c1 ^ c0;
         endcase
         m_cap[g] = (m_cap[g] & ~clr) | ev;
         if (wr && address == 2'd2) m_mask[g] = writedata[3:0];
      end
`ifdef PIO_IN_DEBOUNCE_EN
      for (int b = 0; b < 4; b++) begin
         if (n >= DC + 2) begin
            logic ok;
            ok = 1'b1;
            for (int m = n - DC + 1; m <= n; m++)
               if (hist[m-3][b] == m_filt[b]) ok = 1'b0;
            if (ok) m_filt[b] = hist[n-3][b];
         end
      end
      cnew = m_filt;
`else
      cnew = (n >= 2) ? hist[n-2] : 4'h0;
`endif
      condq.push_back(cnew);
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_check(string tag);
      logic [31:0] e;
      logic [3:0]  c;
      c = (condq.size() > 0) ? condq[condq.size()-1] : 4'h0;
      for (int g = 0; g < 4; g++) begin
         case (address)
            2'd0:    e = {28'd0, c};
            2'd1:    e = '0;
            2'd2:    e = {28'd0, m_mask[g]};
            default: e = {28'd0, m_cap[g]};
         endcase
         chk($sformatf("%s rd[%0d]", tag, g), rd[g], e);
         chk($sformatf("%s irq[%0d]", tag, g), {31'd0, irq[g]},
             {31'd0, |(m_cap[g] & m_mask[g])});
      end
   endtask

   // Inputs change at the falling edge; outputs are checked one falling edge later.
   task automatic step(string tag, logic rn, logic [1:0] a, logic cs, logic wn,
                       logic [31:0] wd, logic [3:0] ip);
      reset_n    = rn;
      address    = a;
      chipselect = cs;
      write_n    = wn;
      writedata  = wd;
      in_port    = ip;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_check(tag);
   endtask

   typedef struct {
      logic        rn;
      logic [1:0]  a;
      logic        cs;
      logic        wn;
      logic [31:0] wd;
      logic [3:0]  ip;
      logic [31:0] erd;   // expected readdata of the EDGE_TYPE=0 instance
      logic        eirq;
   } vec_t;

   vec_t vt [$];

   initial begin
      // reset with inputs held, warm-up, rising edge + W1C, set-vs-clear race,
      // mask enabling irq, ignored writes
      vt.push_back('{1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 4'hA, 32'h0, 1'b0});
      vt.push_back('{1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 4'hA, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 4'hA, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 4'hA, 32'hA, 1'b0});
      vt.push_back('{1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 4'hA, 32'hA, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hA, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd2, 1'b1, 1'b0, 32'h1, 4'hA, 32'h1, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hB, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hB, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hB, 32'h1, 1'b1});
      vt.push_back('{1'b1, 2'd3, 1'b1, 1'b0, 32'h1, 4'hB, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b1, 1'b0, 32'h4, 4'hF, 32'h4, 1'b0});
      vt.push_back('{1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 4'hD, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b1, 1'b0, 32'hF, 4'hD, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hF, 32'h2, 1'b0});
      vt.push_back('{1'b1, 2'd2, 1'b1, 1'b0, 32'h2, 4'hF, 32'h2, 1'b1});
      vt.push_back('{1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 4'hF, 32'hF, 1'b1});
      vt.push_back('{1'b1, 2'd1, 1'b1, 1'b0, 32'hF, 4'hF, 32'h0, 1'b1});
      vt.push_back('{1'b1, 2'd3, 1'b1, 1'b0, 32'hF, 4'hF, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'd2, 1'b0, 1'b0, 32'hF, 4'hF, 32'h2, 1'b0});

      @(negedge clk);
      for (int i = 0; i < vt.size(); i++) begin
         step($sformatf("vec%0d", i), vt[i].rn, vt[i].a, vt[i].cs, vt[i].wn, vt[i].wd, vt[i].ip);
`ifndef PIO_IN_DEBOUNCE_EN
         chk($sformatf("vec%0d et0 rd", i), rd[0], vt[i].erd);
         chk($sformatf("vec%0d et0 irq", i), {31'd0, irq[0]}, {31'd0, vt[i].eirq});
`endif
      end

      // bit3 high for five cycles: rise and fall both seen by EDGE_TYPE 2
      for (int i = 0; i < 3; i++) step("pre", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'h7);
      step("pre clr", 1'b1, 2'd3, 1'b1, 1'b0, 32'hF, 4'h7);
      for (int i = 0; i < 5; i++) step("pulse hi", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
      for (int i = 0; i < 5; i++) step("pulse lo", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'h7);
`ifndef PIO_IN_DEBOUNCE_EN
      chk("et2 cap bit3 after pulse", rd[2] & 32'h8, 32'h8);
      chk("et1 cap bit3 on fall", rd[1], 32'h8);
`endif
      step("addr1", 1'b1, 2'd1, 1'b0, 1'b1, 32'h0, 4'h7);
      chk("et2 addr1 reads 0", rd[2], 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
      step("db clr", 1'b1, 2'd3, 1'b1, 1'b0, 32'hF, 4'h6);
      for (int i = 0; i < 30; i++) step("db settle", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'h6);
      for (int i = 0; i < 10; i++) step("db short", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'h7);
      for (int i = 0; i < 30; i++) step("db short tail", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'h6);
      chk("db short pulse ignored", rd[0], 32'h0);
      for (int i = 0; i < 20; i++) step("db long", 1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 4'h7);
      chk("db long pulse data", rd[0] & 32'h1, 32'h1);
      for (int i = 0; i < 8; i++) step("db pre-reset", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'h6);
      step("db reset", 1'b0, 2'd3, 1'b0, 1'b1, 32'h0, 4'h6);
      chk("db reset cap", rd[0], 32'h0);
      for (int i = 0; i < 30; i++) step("db post-reset", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 4'h0);
`endif

      // random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         logic [3:0] ip;
         ip = ($urandom_range(0, 3) == 0) ? 4'($urandom) : in_port;
         step("rand", ($urandom_range(0, 59) != 0), 2'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0), $urandom, ip);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/niosdram_pio_in.md
Name: niosdram_pio_in

Overview:
- Avalon-MM slave parallel input port: the input-direction counterpart of the existing output PIO on the Nios/SDRAM system bus.
- Samples an external WIDTH-bit bus through a 2-flop synchronizer.
- Detects per-bit edges into a sticky edge-capture register and raises a level irq to the Nios when any captured, unmasked bit is set.
- Sits beside the output PIO on the same interconnect, with zero-wait-state reads.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 0, edge to capture: 0 rising, 1 falling, 2 any.
- RESET_MASK, 0, reset value of the interrupt-mask register (WIDTH bits).
- DEBOUNCE_CYCLES, 16, stable-cycle count for the optional debounce filter (>=2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data; only [WIDTH-1:0] used.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  combinational read data, zero-extended.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Register map:
  - 0 DATA: read-only, returns the conditioned input; writes ignored.
  - 1: reads 0, writes ignored.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; a write clears each bit where writedata is 1 (write-1-to-clear).
- Write is qualified by chipselect && !write_n, committed on the clock edge.
- Read: readdata = mux(address) of register contents, zero-wait, independent of chipselect; bits [31:WIDTH] always 0.
- Pipeline, per clock: s1<=in_port; s2<=s1; cond = s2 (or the debounce output); prev<=cond.
- Edge term: rise = cond&~prev, fall = ~cond&prev, any = cond^prev, selected by EDGE_TYPE.
- Latency: in_port change before edge k is seen at DATA after edge k+1; EDGECAP bit set after edge k+2; irq asserts in the same cycle as the EDGECAP bit.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- Warm-up FSM, states WARM0 -> WARM1 -> RUN:
  - Entered on reset; advances one state per clock.
  - In WARM0/WARM1 edge detection is suppressed and prev tracks cond, so a steady-high input after reset never produces a spurious edge.
  - RUN is terminal until reset.
- Simultaneous events:
  - Edge detected on a bit in the same cycle as a write-1-to-clear of that bit: the set wins (bit stays 1).
  - Edges on other bits are never lost.
- EDGECAP bits are sticky until cleared by software or reset; repeated edges on a set bit have no further effect.
- Reset (any cycle, including mid-edge): s1, s2, prev, EDGECAP = 0; IRQMASK = RESET_MASK; FSM = WARM0; irq = 0 (when RESET_MASK is irrelevant because EDGECAP=0); readdata at address 0 reads 0 until in_port propagates.
- Undefined EDGE_TYPE value (3) behaves as 2 (any edge).

Optional Feature:
- Macro PIO_IN_DEBOUNCE_EN.
- Defined: a per-bit debounce filter is inserted between s2 and cond.
  - Each bit has a counter of clog2(DEBOUNCE_CYCLES) bits.
  - Counter clears when s2 == filtered; otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 with s2 still != filtered, filtered <= s2 and the counter clears.
  - A change must hold for DEBOUNCE_CYCLES consecutive clocks before it is seen; any shorter glitch is discarded.
  - During WARM0/WARM1, filtered loads s2 directly.
  - Reset clears filtered and all counters.
- Not defined: cond = s2; no counters are instantiated; latency is as stated above.

Test Plan:
- Reset, in_port=4'b1010 held, no access -> after 3 clocks read addr 0 = 0x0000000A; EDGECAP=0; irq=0 throughout (warm-up suppresses the edge).
- EDGE_TYPE=0, IRQMASK=4'b0001: in_port bit0 0->1 -> EDGECAP=0x1 two clocks after sampling; irq=1 same cycle; write 0x1 to addr 3 -> EDGECAP=0, irq=0 next cycle.
- Rising edge on bit2 lands in the same cycle as a write of 0x4 to addr 3 -> EDGECAP bit2 remains 1.
- IRQMASK=0, edge on bit1 -> EDGECAP=0x2, irq=0; then write 0x2 to addr 2 -> irq=1 next cycle; write addr 0 = 0xF -> DATA unchanged.
- EDGE_TYPE=2: bit3 pulses 1 for 5 cycles -> EDGECAP bit3 set on the rise, stays set through the fall; address 1 reads 0.
- PIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: a 10-cycle pulse on bit0 -> DATA and EDGECAP unchanged; a 20-cycle pulse -> DATA bit0=1 exactly 16 cycles after s2 changes, EDGECAP bit0 set one cycle later; reset asserted mid-count -> all counters and EDGECAP read 0.
